rate_limit_mc: RTL and testbench
================================

RATE_LIMIT_MC -- requirements
Module: rate_limit_mc

Interface
REQ-001 SHALL have parameters: W=32 (payload width), CH=4 (channel count, 2..16), CW=6 (credit width), PW=5 (period width), CREDIT_INIT=0 (per-bucket reset credit).
REQ-002 SHALL have ports: clk  in  1  sole clock, all state rising-edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports: cfg_period  in  PW  refill interval minus one; cfg_inc  in  CW  credits per refill; cfg_max  in  CW  bucket cap.
REQ-005 SHALL have ports: cfg_en  in  CH  per-channel enable.
REQ-006 SHALL have ports: in_valid  in  CH; in_data  in  CH*W  (channel i at [i*W +: W]); in_ready  out  CH.
REQ-007 SHALL have ports: out_valid  out  1; out_data  out  W; out_ch  out  $clog2(CH)  source channel; out_ready  in  1.
REQ-008 SHALL have ports: credit_r  out  CH*CW  current bucket levels (channel i at [i*CW +: CW]).

Function
REQ-009 SHALL run a period counter 0..cfg_period; refill pulse when cnt_r >= cfg_period, counter then returns to 0 (a lowered cfg_period with cnt_r above it refills next cycle).
REQ-010 SHALL compute per bucket: next = min(credit - grant + (refill ? cfg_inc : 0), cfg_max), evaluated at CW+1 bits, no wrap; refill and grant in the same cycle both apply.
REQ-011 SHALL keep a bucket above a lowered cfg_max unchanged until its next refill or grant; cfg_inc=0 means no refill; cfg_max=0 clips the bucket to 0 at the next refill or grant and blocks the channel.
REQ-012 SHALL treat a channel as eligible when cfg_en[i] & in_valid[i] & credit[i]!=0; buckets of disabled channels keep refilling.
REQ-013 SHALL grant at most one eligible channel per cycle, round-robin, pointer moving to granted+1 mod CH only on a grant.
REQ-014 SHALL grant only when the output register is empty or out_ready=1 in that cycle.
REQ-015 SHALL drive in_ready[i]=grant[i] combinationally; a beat transfers on in_valid[i]&in_ready[i], consuming exactly one credit.
REQ-016 SHALL register granted data/channel: grant in cycle N -> out_valid=1 in cycle N+1; back-to-back grants sustain one beat per cycle under out_ready=1.
REQ-017 SHALL hold out_valid, out_data, out_ch stable while out_valid=1 and out_ready=0; out_valid clears after a pop with no new grant.

Reset
REQ-018 SHALL on rst_n=0 immediately set cnt_r=0, every bucket=CREDIT_INIT, RR pointer=0, out_valid=0, out_data=0, out_ch=0, in_ready=0.
REQ-019 SHALL discard an in-flight output beat on reset mid-operation; first refill occurs cfg_period+1 cycles after reset release.

Configuration
REQ-020 SHALL, with RATE_LIMIT_MC_STATS_EN defined, add output stat_grant  out  CH*16: per-channel 16-bit saturating grant counters, reset to 0.
REQ-021 SHALL, without RATE_LIMIT_MC_STATS_EN, omit stat_grant and its counters; all other behaviour identical.

Structure
REQ-022 SHALL place parameter defaults and credit_t/period_t typedefs in package rate_limit_mc_pkg.
REQ-023 SHALL implement each bucket (REQ-010/011) as sub-module rate_limit_mc_bucket, instantiated CH times; counter, arbiter, output register in top.

Verification
REQ-024 SHALL cover: CREDIT_INIT=0, cfg_period=14, cfg_inc=13, cfg_max=16, ch0 always valid, out_ready=1 -> exactly 13 beats per 15 cycles steady state.
REQ-025 SHALL cover: all 4 channels valid, ample credit -> grants 0,1,2,3,0,... one per cycle; out_ch matches.
REQ-026 SHALL cover: bucket=16, refill of 13 with simultaneous grant -> bucket=16 (clipped), not 15 or 28.
REQ-027 SHALL cover: out_ready=0 for 5 cycles with out_valid=1 -> data/ch stable, no grants, no credit consumed.
REQ-028 SHALL cover: cfg_en=4'b0010 with all valid -> only ch1 granted; disabled buckets reach cfg_max and stay there.
REQ-029 SHALL cover: rst_n low mid-stream -> out_valid=0 and credit_r=CREDIT_INIT immediately, without a clock edge.

Source files
------------

// File: rtl/rate_limit_mc_pkg.sv
// -----------------------------------------------------------------------------
// rate_limit_mc_pkg
// Purpose : shared parameter defaults, credit/period typedefs and small helper
//           functions for the multi-channel token-bucket rate limiter.
// Contents: RL_*_DEF   default values for the rate_limit_mc parameters
//           credit_t   bucket level at the default credit width
//           period_t   refill interval at the default period width
//           sat_inc16  16-bit saturating increment (grant statistics)
// -----------------------------------------------------------------------------
package rate_limit_mc_pkg;

   localparam int RL_W_DEF           = 32;
   localparam int RL_CH_DEF          = 4;
   localparam int RL_CW_DEF          = 6;
   localparam int RL_PW_DEF          = 5;
   localparam int RL_CREDIT_INIT_DEF = 0;
   localparam int RL_STAT_W          = 16;

   typedef logic [RL_CW_DEF-1:0] credit_t;
   typedef logic [RL_PW_DEF-1:0] period_t;

   // Counter sticks at all-ones instead of wrapping back to zero.
   function automatic logic [RL_STAT_W-1:0] sat_inc16(input logic [RL_STAT_W-1:0] v);
      logic [RL_STAT_W-1:0] r;
      if (v == {RL_STAT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(RL_STAT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/rate_limit_mc_if.sv
// -----------------------------------------------------------------------------
// rate_limit_mc_if
// Purpose : data-path handshake bundle of the rate limiter.
// Signals : in_valid  [CH]     per-channel request valid
//           in_data   [CH*W]   per-channel payload, channel i at [i*W +: W]
//           in_ready  [CH]     per-channel accept (combinational grant)
//           out_valid          registered output beat valid
//           out_data  [W]      registered output payload
//           out_ch    [log2CH] source channel of the output beat
//           out_ready          downstream accept
// Modports: master = traffic source/sink side, slave = rate limiter side.
// -----------------------------------------------------------------------------
interface rate_limit_mc_if
   import rate_limit_mc_pkg::*;
#(
   parameter int W  = RL_W_DEF,
   parameter int CH = RL_CH_DEF
) ();

   localparam int CHW = $clog2(CH);

   logic [CH-1:0]   in_valid;
   logic [CH*W-1:0] in_data;
   logic [CH-1:0]   in_ready;
   logic            out_valid;
   logic [W-1:0]    out_data;
   logic [CHW-1:0]  out_ch;
   logic            out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );

endinterface

// File: rtl/rate_limit_mc_bucket.sv
// -----------------------------------------------------------------------------
// rate_limit_mc_bucket
// Purpose : one token bucket. On a refill and/or grant the level becomes
//           min(credit - grant + (refill ? inc : 0), max), computed one bit
//           wider than the bucket so it never wraps. Without refill or grant
//           the level is held, so a bucket above a lowered cap keeps its value
//           until its next update.
// Ports   : clk, rst_n      clock, async active-low reset
//           i_refill        refill pulse from the shared period counter
//           i_grant         one credit consumed this cycle
//           i_inc, i_max    credits per refill, bucket cap
//           o_credit        current bucket level (register)
// -----------------------------------------------------------------------------
module rate_limit_mc_bucket
   import rate_limit_mc_pkg::*;
#(
   parameter int CW          = RL_CW_DEF,
   parameter int CREDIT_INIT = RL_CREDIT_INIT_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_refill,
   input  logic          i_grant,
   input  logic [CW-1:0] i_inc,
   input  logic [CW-1:0] i_max,
   output logic [CW-1:0] o_credit
);

   logic [CW-1:0] r_credit;
   logic [CW:0]   w_add;
   logic [CW:0]   w_sum;
   logic [CW-1:0] w_next;
   logic          w_upd;

   // Next level: subtract grant, add refill, clip to the cap.
   always_comb begin
      w_add  = {(CW+1){1'b0}};
      w_sum  = {(CW+1){1'b0}};
      w_next = r_credit;
      w_upd  = i_refill | i_grant;
      if (i_refill) begin
         w_add = {1'b0, i_inc};
      end else begin
         w_add = {(CW+1){1'b0}};
      end
      // A grant is only issued on a non-empty bucket, so this never underflows.
      w_sum = {1'b0, r_credit} - {{CW{1'b0}}, i_grant} + w_add;
      if (w_sum > {1'b0, i_max}) begin
         w_next = i_max;
      end else begin
         w_next = w_sum[CW-1:0];
      end
   end

   // Bucket level register, updated only on refill or grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credit <= CW'(CREDIT_INIT);
      end else if (w_upd) begin
         r_credit <= w_next;
      end else begin
         r_credit <= r_credit;
      end
   end

   assign o_credit = r_credit;

endmodule

// File: rtl/rate_limit_mc.sv
// -----------------------------------------------------------------------------
// rate_limit_mc
// Purpose : multi-channel token-bucket rate limiter. A shared period counter
//           emits a refill pulse every cfg_period+1 cycles; each channel owns a
//           bucket (rate_limit_mc_bucket). Channels that are enabled, valid and
//           hold credit compete in a round-robin arbiter; at most one beat per
//           cycle is granted and captured in a single output register.
// Ports   : clk, rst_n            clock, async active-low reset
//           cfg_period [PW]       refill interval minus one
//           cfg_inc    [CW]       credits added per refill
//           cfg_max    [CW]       bucket cap
//           cfg_en     [CH]       per-channel enable
//           bus (slave)           in_valid/in_data/in_ready, out_valid/
//                                 out_data/out_ch/out_ready
//           credit_r   [CH*CW]    bucket levels, channel i at [i*CW +: CW]
//           stat_grant [CH*16]    saturating per-channel grant counters,
//                                 present only with RATE_LIMIT_MC_STATS_EN
// Build   : define RATE_LIMIT_MC_STATS_EN to add the stat_grant output.
// -----------------------------------------------------------------------------
module rate_limit_mc
   import rate_limit_mc_pkg::*;
#(
   parameter int W           = RL_W_DEF,
   parameter int CH          = RL_CH_DEF,
   parameter int CW          = RL_CW_DEF,
   parameter int PW          = RL_PW_DEF,
   parameter int CREDIT_INIT = RL_CREDIT_INIT_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PW-1:0]      cfg_period,
   input  logic [CW-1:0]      cfg_inc,
   input  logic [CW-1:0]      cfg_max,
   input  logic [CH-1:0]      cfg_en,
   rate_limit_mc_if.slave     bus,
   output logic [CH*CW-1:0]   credit_r
`ifdef RATE_LIMIT_MC_STATS_EN
   ,
   output logic [CH*RL_STAT_W-1:0] stat_grant
`endif
);

   localparam int CHW = $clog2(CH);

   logic [PW-1:0]  r_cnt;
   logic           w_refill;
   logic [CW-1:0]  w_credit [CH];
   logic [CH-1:0]  w_elig;
   logic           w_found;
   logic [CHW-1:0] w_gnt_idx;
   logic           w_can_accept;
   logic           w_gnt_vld;
   logic [CH-1:0]  w_gnt;
   logic [CHW-1:0] r_ptr;
   logic           r_out_valid;
   logic [W-1:0]   r_out_data;
   logic [CHW-1:0] r_out_ch;

   // ---------------------------------------------------------------- period
   // ">=" rather than "==" so a lowered cfg_period below the count still
   // produces a refill on the next cycle instead of waiting for a wrap.
   assign w_refill = (r_cnt >= cfg_period);

   // Period counter: counts 0..cfg_period and restarts on the refill pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {PW{1'b0}};
      end else if (w_refill) begin
         r_cnt <= {PW{1'b0}};
      end else begin
         r_cnt <= r_cnt + {{(PW-1){1'b0}}, 1'b1};
      end
   end

   // --------------------------------------------------------------- buckets
   for (genvar g = 0; g < CH; g++) begin : g_bucket
      rate_limit_mc_bucket #(
         .CW          (CW),
         .CREDIT_INIT (CREDIT_INIT)
      ) u_bucket (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_refill (w_refill),
         .i_grant  (w_gnt[g]),
         .i_inc    (cfg_inc),
         .i_max    (cfg_max),
         .o_credit (w_credit[g])
      );

      assign credit_r[g*CW +: CW] = w_credit[g];
      // Disabled channels are never eligible, but their buckets keep refilling.
      assign w_elig[g] = cfg_en[g] & bus.in_valid[g] & (w_credit[g] != {CW{1'b0}});
   end

   // ------------------------------------------------------------- arbiter
   // Round-robin search from the pointer for the first eligible channel.
   always_comb begin : p_arb
      logic [CHW:0] v_cand;
      v_cand    = {(CHW+1){1'b0}};
      w_found   = 1'b0;
      w_gnt_idx = {CHW{1'b0}};
      for (int k = 0; k < CH; k++) begin
         v_cand = {1'b0, r_ptr} + (CHW+1)'(k);
         if (v_cand >= (CHW+1)'(CH)) begin
            v_cand = v_cand - (CHW+1)'(CH);
         end else begin
            v_cand = v_cand;
         end
         if (!w_found && w_elig[v_cand[CHW-1:0]]) begin
            w_found   = 1'b1;
            w_gnt_idx = v_cand[CHW-1:0];
         end else begin
            w_found   = w_found;
            w_gnt_idx = w_gnt_idx;
         end
      end
   end

   // Grant only when the output slot frees up this cycle. rst_n gates the
   // grant so in_ready drops the moment reset asserts, even if CREDIT_INIT
   // leaves the buckets non-empty.
   always_comb begin
      w_can_accept = ~r_out_valid | bus.out_ready;
      w_gnt_vld    = w_found & w_can_accept & rst_n;
      if (w_gnt_vld) begin
         w_gnt = {{(CH-1){1'b0}}, 1'b1} << w_gnt_idx;
      end else begin
         w_gnt = {CH{1'b0}};
      end
   end

   assign bus.in_ready = w_gnt;

   // Round-robin pointer: moves past the winner, only on a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= {CHW{1'b0}};
      end else if (w_gnt_vld) begin
         if (w_gnt_idx == CHW'(CH-1)) begin
            r_ptr <= {CHW{1'b0}};
         end else begin
            r_ptr <= w_gnt_idx + {{(CHW-1){1'b0}}, 1'b1};
         end
      end else begin
         r_ptr <= r_ptr;
      end
   end

   // ------------------------------------------------------ output register
   // Output slot: load on grant, clear on pop without grant, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= {W{1'b0}};
         r_out_ch    <= {CHW{1'b0}};
      end else if (w_gnt_vld) begin
         r_out_valid <= 1'b1;
         r_out_data  <= bus.in_data[w_gnt_idx*W +: W];
         r_out_ch    <= w_gnt_idx;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
         r_out_data  <= r_out_data;
         r_out_ch    <= r_out_ch;
      end else begin
         r_out_valid <= r_out_valid;
         r_out_data  <= r_out_data;
         r_out_ch    <= r_out_ch;
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_ch    = r_out_ch;

`ifdef RATE_LIMIT_MC_STATS_EN
   // ------------------------------------------------------------ statistics
   for (genvar s = 0; s < CH; s++) begin : g_stat
      logic [RL_STAT_W-1:0] r_stat;

      // Per-channel grant counter, saturating at all-ones.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_stat <= {RL_STAT_W{1'b0}};
         end else if (w_gnt[s]) begin
            r_stat <= sat_inc16(r_stat);
         end else begin
            r_stat <= r_stat;
         end
      end

      assign stat_grant[s*RL_STAT_W +: RL_STAT_W] = r_stat;
   end
`endif

endmodule

// File: tb/tb_rate_limit_mc.sv
// -----------------------------------------------------------------------------
// tb_rate_limit_mc
// Self-checking bench for rate_limit_mc: a behavioural model (integer buckets,
// integer period counter, integer round-robin pointer) runs alongside the DUT
// every cycle; a vector table covers arbitration/handshake with hand-derived
// expectations; short directed sequences cover rate, clipping, back-pressure,
// disabled channels and asynchronous reset; then a randomized phase.
// Build option: RATE_LIMIT_MC_STATS_EN also checks stat_grant.
// -----------------------------------------------------------------------------
module tb_rate_limit_mc;
   import rate_limit_mc_pkg::*;

   timeunit 1ns;
   timeprecision 1ps;

   localparam int W  = 32;
   localparam int CH = 4;
   localparam int CW = 6;
   localparam int PW = 5;
   localparam int CI = 0;

   logic             clk = 1'b0;
   logic             rst_n;
   period_t          cfg_period;
   credit_t          cfg_inc;
   credit_t          cfg_max;
   logic [CH-1:0]    cfg_en;
   logic [CH*CW-1:0] credit_r;
`ifdef RATE_LIMIT_MC_STATS_EN
   logic [CH*16-1:0] stat_grant;
`endif

   rate_limit_mc_if #(.W(W), .CH(CH)) bus ();

   rate_limit_mc #(
      .W(W), .CH(CH), .CW(CW), .PW(PW), .CREDIT_INIT(CI)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_period (cfg_period),
      .cfg_inc    (cfg_inc),
      .cfg_max    (cfg_max),
      .cfg_en     (cfg_en),
      .bus        (bus),
      .credit_r   (credit_r)
`ifdef RATE_LIMIT_MC_STATS_EN
      ,
      .stat_grant (stat_grant)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------------------------------------------------------- model
   int            m_cnt;
   int            m_cr   [CH];
   int            m_stat [CH];
   int            m_ptr;
   bit            m_ov;
   logic [W-1:0]  m_od;
   int            m_och;
   int            m_gnt;
   bit            m_refill;
   logic [CH-1:0] s_in_ready;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_ptr = 0;
      m_ov  = 1'b0;
      m_od  = '0;
      m_och = 0;
      m_gnt = -1;
      for (int i = 0; i < CH; i++) begin
         m_cr[i]   = CI;
         m_stat[i] = 0;
      end
   endtask

   // Decide this cycle's refill and winner from the current inputs.
   task automatic model_comb();
      int c;
      m_refill = (m_cnt >= int'(cfg_period));
      m_gnt    = -1;
      if (!m_ov || bus.out_ready) begin
         for (int k = 0; k < CH; k++) begin
            c = (m_ptr + k) % CH;
            if (m_gnt < 0 && cfg_en[c] && bus.in_valid[c] && m_cr[c] != 0) m_gnt = c;
         end
      end
   endtask

   // Apply the clock edge to the model.
   task automatic model_seq();
      int v;
      for (int i = 0; i < CH; i++) begin
         if (m_refill || m_gnt == i) begin
            v = m_cr[i] - ((m_gnt == i) ? 1 : 0) + (m_refill ? int'(cfg_inc) : 0);
            m_cr[i] = (v > int'(cfg_max)) ? int'(cfg_max) : v;
         end
      end
      if (m_gnt >= 0) begin
         m_ov  = 1'b1;
         m_od  = bus.in_data[m_gnt*W +: W];
         m_och = m_gnt;
         m_ptr = (m_gnt + 1) % CH;
         if (m_stat[m_gnt] < 65535) m_stat[m_gnt]++;
      end else if (bus.out_ready) begin
         m_ov = 1'b0;
      end
      m_cnt = m_refill ? 0 : m_cnt + 1;
   endtask

   // One clock cycle: compare mid-cycle at the falling edge, then advance.
   task automatic step();
      logic [CH-1:0]    exp_rdy;
      logic [CH*CW-1:0] exp_cr;
      @(negedge clk);
      model_comb();
      exp_rdy = '0;
      if (m_gnt >= 0) exp_rdy[m_gnt] = 1'b1;
      for (int i = 0; i < CH; i++) exp_cr[i*CW +: CW] = CW'(m_cr[i]);
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("out_valid", bus.out_valid, m_ov);
      if (m_ov) begin
         chk("out_data", bus.out_data, m_od);
         chk("out_ch", bus.out_ch, m_och);
      end
      chk("credit_r", credit_r, exp_cr);
`ifdef RATE_LIMIT_MC_STATS_EN
      for (int i = 0; i < CH; i++) chk("stat_grant", stat_grant[i*16 +: 16], m_stat[i]);
`endif
      s_in_ready = bus.in_ready;
      @(posedge clk);
      model_seq();
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [W-1:0] tbl_data(input int r, input int c);
      return 32'hA500_0000 | (32'(r) << 8) | 32'(c);
   endfunction

   // ---------------------------------------------------------------- table
   typedef struct {
      logic [CH-1:0] valid;
      logic [CH-1:0] en;
      logic          rdy;
      logic [CH-1:0] exp_rdy;
      logic          exp_ov;
      int            exp_ch;
      int            dr;      // table row whose data sits in the output slot
   } vec_t;

   vec_t tbl [15];

   initial begin
      logic [W-1:0]  d0;
      logic [CH-1:0] bad;
      int            n;
      int            grants;

      tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 0, 0};
      tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 1, 1};
      tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2, 2};
      tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 3, 3};
      tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 0, 4};
      tbl[5]  = '{4'h9, 4'hF, 1'b1, 4'h8, 1'b1, 3, 5};
      tbl[6]  = '{4'h9, 4'hF, 1'b1, 4'h1, 1'b1, 0, 6};
      tbl[7]  = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 0, 0};
      tbl[8]  = '{4'h4, 4'hF, 1'b0, 4'h4, 1'b1, 2, 8};
      tbl[9]  = '{4'h3, 4'hF, 1'b0, 4'h0, 1'b1, 2, 8};
      tbl[10] = '{4'h3, 4'hF, 1'b1, 4'h1, 1'b1, 0, 10};
      tbl[11] = '{4'hF, 4'h6, 1'b1, 4'h2, 1'b1, 1, 11};
      tbl[12] = '{4'hF, 4'h6, 1'b1, 4'h4, 1'b1, 2, 12};
      tbl[13] = '{4'hF, 4'h6, 1'b1, 4'h2, 1'b1, 1, 13};
      tbl[14] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 0, 0};

      // ---- reset state
      cfg_period    = 5'd0;
      cfg_inc       = 6'd63;
      cfg_max       = 6'd63;
      cfg_en        = 4'hF;
      bus.in_valid  = 4'hF;
      bus.in_data   = '1;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_ch", bus.out_ch, 0);
      chk("rst_credit", credit_r, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      do_reset();

      // ---- table: refill every cycle to the 63 cap, so credit never limits
      step();
      for (int r = 0; r < 15; r++) begin
         bus.in_valid  = tbl[r].valid;
         cfg_en        = tbl[r].en;
         bus.out_ready = tbl[r].rdy;
         for (int c = 0; c < CH; c++) bus.in_data[c*W +: W] = tbl_data(r, c);
         step();
         chk($sformatf("tbl%0d_in_ready", r), s_in_ready, tbl[r].exp_rdy);
         chk($sformatf("tbl%0d_out_valid", r), bus.out_valid, tbl[r].exp_ov);
         if (tbl[r].exp_ov) begin
            chk($sformatf("tbl%0d_out_ch", r), bus.out_ch, tbl[r].exp_ch);
            chk($sformatf("tbl%0d_out_data", r), bus.out_data, tbl_data(tbl[r].dr, tbl[r].exp_ch));
         end
      end

      // ---- 13 beats per 15 cycles on a single saturated channel
      cfg_period = 5'd14;
      cfg_inc    = 6'd13;
      cfg_max    = 6'd16;
      cfg_en     = 4'h1;
      do_reset();
      bus.in_valid = 4'h1;
      for (int i = 0; i < 30; i++) step();
      grants = 0;
      for (int i = 0; i < 150; i++) begin
         bus.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
         if (s_in_ready[0]) grants++;
      end
      chk("rate_13_per_15", grants, 130);

      // ---- full bucket: refill and grant in the same cycle stays at the cap
      do_reset();
      n = 0;
      while (!(m_cnt == 14 && m_cr[0] == 16) && n < 100) begin
         step();
         n++;
      end
      chk("pre_refill_bucket", credit_r[CW-1:0], 16);
      d0 = 32'h1234_5678;
      bus.in_data[W-1:0] = d0;
      bus.in_valid = 4'h1;
      step();
      chk("refill_grant_clip", credit_r[CW-1:0], 16);
      chk("refill_grant_ov", bus.out_valid, 1);

      // ---- back-pressure: 5 cycles with out_ready low
      bus.out_ready = 1'b0;
      bus.in_valid  = 4'hF;
      cfg_en        = 4'hF;
      for (int i = 0; i < 5; i++) begin
         bus.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
         chk("hold_no_grant", s_in_ready, 0);
      end
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_out_data", bus.out_data, d0);
      chk("hold_out_ch", bus.out_ch, 0);
      chk("hold_credit", credit_r[CW-1:0], 16);
      bus.in_valid  = 4'h0;
      bus.out_ready = 1'b1;
      step();
      chk("pop_clears_valid", bus.out_valid, 0);

      // ---- only channel 1 enabled; the others fill to the cap and stay
      cfg_period = 5'd3;
      cfg_inc    = 6'd2;
      cfg_max    = 6'd5;
      cfg_en     = 4'b0010;
      do_reset();
      bus.in_valid = 4'hF;
      bad = '0;
      for (int i = 0; i < 40; i++) begin
         bus.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
         bad = bad | (s_in_ready & 4'b1101);
      end
      chk("en_only_ch1", bad, 0);
      chk("dis_bucket0", credit_r[0*CW +: CW], 5);
      chk("dis_bucket2", credit_r[2*CW +: CW], 5);
      chk("dis_bucket3", credit_r[3*CW +: CW], 5);

      // ---- randomized traffic and configuration
      do_reset();
      for (int seg = 0; seg < 20; seg++) begin
         cfg_period = PW'($urandom_range(0, 9));
         cfg_inc    = CW'($urandom_range(0, 9));
         cfg_max    = CW'($urandom_range(0, 24));
         cfg_en     = CH'($urandom_range(0, 15));
         for (int i = 0; i < 100; i++) begin
            bus.in_valid  = CH'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
         end
      end

      // ---- asynchronous reset mid-stream
      cfg_period    = 5'd0;
      cfg_inc       = 6'd63;
      cfg_max       = 6'd63;
      cfg_en        = 4'hF;
      bus.in_valid  = 4'hF;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("pre_reset_ov", bus.out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", bus.out_valid, 0);
      chk("async_rst_credit", credit_r, 0);
      chk("async_rst_in_ready", bus.in_ready, 0);
      chk("async_rst_out_data", bus.out_data, 0);
      chk("async_rst_out_ch", bus.out_ch, 0);

      // ---- first refill lands cfg_period+1 cycles after release
      cfg_period = 5'd4;
      cfg_inc    = 6'd3;
      cfg_max    = 6'd10;
      do_reset();
      for (int i = 0; i < 4; i++) step();
      chk("no_refill_before", credit_r[CW-1:0], 0);
      step();
      chk("first_refill", credit_r[CW-1:0], 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
